// File: rtl/wave_meas.sv
// Waveform period / high-time / duty-cycle meter.
// The sample stream is sliced against a threshold, rising edges delimit periods, and each
// completed period is handed to a sequential restoring divider that produces the duty ratio.
module wave_meas #(
   parameter int unsigned WAVE_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [WAVE_WIDTH-1:0] wave_in,
   input  logic [WAVE_WIDTH-1:0] threshold,
   output logic [CNT_WIDTH-1:0]  period,
   output logic [CNT_WIDTH-1:0]  high_time,
   output logic [CNT_WIDTH-1:0]  duty_cyc,
   output logic                  meas_valid,
   output logic                  overrun,
   output logic                  timeout
);

   localparam int unsigned StepW = (CNT_WIDTH > 1) ? $clog2(CNT_WIDTH) : 1;
   localparam logic [StepW-1:0]     StepLast = StepW'(CNT_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;
   localparam logic [CNT_WIDTH-1:0] CntTop   = CntMax - CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StSync, StMeasure} state_e;
   typedef enum logic {DivIdle, DivBusy} div_e;

   state_e                 state_q;
   div_e                   div_q;
   logic                   lvl_r, lvl_d;
   logic                   rise;
   logic                   capture, start_div;
   logic [CNT_WIDTH-1:0]   per_cnt_q, high_cnt_q;
   logic [CNT_WIDTH-1:0]   rem_q, num_lo_q, den_q, high_cap_q;
   logic [StepW-1:0]       step_q;
   logic [2*CNT_WIDTH-1:0] num_full;
   logic [CNT_WIDTH:0]     rem_sh;
   logic                   rem_ge;
   logic [CNT_WIDTH-1:0]   rem_nxt, quo_nxt;

   // Slice and delay the level; only rising edges are used, falling edges never steer control.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl_r <= 1'b0;
         lvl_d <= 1'b0;
      end else begin
         lvl_r <= (wave_in >= threshold);
         lvl_d <= lvl_r;
      end
   end

   assign rise      = lvl_r & ~lvl_d;
   assign capture   = enable & (state_q == StMeasure) & rise;
   assign start_div = capture & (div_q == DivIdle);
   // Dropped captures are flagged in the very cycle the edge is seen.
   assign overrun   = capture & (div_q == DivBusy);

   // Measurement FSM: synchronise on a first edge, then count period and high cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         per_cnt_q  <= '0;
         high_cnt_q <= '0;
         timeout    <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (!enable) begin
            state_q    <= StIdle;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  per_cnt_q  <= '0;
                  high_cnt_q <= '0;
                  state_q    <= StSync;
               end
               StSync: begin
                  if (rise) begin
                     state_q    <= StMeasure;
                     per_cnt_q  <= CntOne;
                     high_cnt_q <= CntOne;
                  end else if (per_cnt_q == CntTop) begin
                     timeout   <= 1'b1;
                     per_cnt_q <= '0;
                  end else begin
                     per_cnt_q <= per_cnt_q + CntOne;
                  end
               end
               StMeasure: begin
                  if (rise) begin
                     per_cnt_q  <= CntOne;
                     high_cnt_q <= CntOne;
                  end else if (per_cnt_q == CntTop) begin
                     timeout    <= 1'b1;
                     state_q    <= StSync;
                     per_cnt_q  <= '0;
                     high_cnt_q <= '0;
                  end else begin
                     per_cnt_q  <= per_cnt_q + CntOne;
                     high_cnt_q <= (high_cnt_q == CntMax) ? high_cnt_q :
                                   high_cnt_q + {{(CNT_WIDTH-1){1'b0}}, lvl_r};
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // high*(2^N-1) = high*2^N - high; its upper half is high-1, already below the divisor.
   // One restoring step: the quotient bit shifts into the freed low end of the dividend.
   always_comb begin
      num_full = {high_cnt_q, {CNT_WIDTH{1'b0}}} - {{CNT_WIDTH{1'b0}}, high_cnt_q};
      rem_sh   = {rem_q, num_lo_q[CNT_WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, den_q});
      rem_nxt  = rem_ge ? CNT_WIDTH'(rem_sh - {1'b0, den_q}) : rem_sh[CNT_WIDTH-1:0];
      quo_nxt  = {num_lo_q[CNT_WIDTH-2:0], rem_ge};
   end

   // Divider sub-machine: CNT_WIDTH steps, then publish results with a one-cycle valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= DivIdle;
         step_q     <= '0;
         rem_q      <= '0;
         num_lo_q   <= '0;
         den_q      <= '0;
         high_cap_q <= '0;
         period     <= '0;
         high_time  <= '0;
         duty_cyc   <= '0;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (!enable) begin
            div_q <= DivIdle;
         end else begin
            unique case (div_q)
               DivIdle: begin
                  if (start_div) begin
                     div_q      <= DivBusy;
                     step_q     <= '0;
                     rem_q      <= num_full[2*CNT_WIDTH-1:CNT_WIDTH];
                     num_lo_q   <= num_full[CNT_WIDTH-1:0];
                     den_q      <= per_cnt_q;
                     high_cap_q <= high_cnt_q;
                  end
               end
               DivBusy: begin
                  rem_q    <= rem_nxt;
                  num_lo_q <= quo_nxt;
                  step_q   <= step_q + StepW'(1);
                  if (step_q == StepLast) begin
                     div_q      <= DivIdle;
                     period     <= den_q;
                     high_time  <= high_cap_q;
                     duty_cyc   <= quo_nxt;
                     meas_valid <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_meas.sv
// Self-checking bench for wave_meas: directed square waves, randomised periods/thresholds,
// enable drop, reset mid-division and a timeout, against a per-period reference model.
module tb_wave_meas;

   localparam int unsigned WW   = 16;
   localparam int unsigned CW   = 16;
   localparam int          FULL = 65535;
   localparam int          LAT  = CW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [WW-1:0] wave_in;
   logic [WW-1:0] threshold;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic [CW-1:0] duty_cyc;
   logic          meas_valid;
   logic          overrun;
   logic          timeout;

   wave_meas #(.WAVE_WIDTH(WW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wave_in    (wave_in),
      .threshold  (threshold),
      .period     (period),
      .high_time  (high_time),
      .duty_cyc   (duty_cyc),
      .meas_valid (meas_valid),
      .overrun    (overrun),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int per;
      int hi;
      int duty;
   } res_t;

   res_t exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   // model of the measurement session
   bit en_m = 1'b0;
   int en_since = 0;
   int tmo_ref = 0;
   bit have_prev = 1'b0;
   int last_cap = 0;
   int due_cyc = 0;
   bit prev_s = 1'b0;
   bit edge_pend = 1'b0;
   int hi_acc = 0;
   int hi_at_edge = 0;
   int exp_per = 0;
   int exp_hi = 0;
   int exp_duty = 0;
   bit rnd_vals = 1'b0;
   // observed pulse tallies
   int n_tmo = 0;
   int n_ov = 0;
   int mark_ov, mark_tmo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
      end
   endtask

   function automatic logic [WW-1:0] lvl_val(input bit hi);
      if (!rnd_vals) return hi ? 16'hFFFF : 16'h0000;
      if (hi) return WW'($urandom_range(65535, int'(threshold)));
      return WW'($urandom_range(int'(threshold) - 1, 0));
   endfunction

   // One clock cycle: predict, drive one sample, check at negedge, fold the sample into the model.
   task automatic step(input logic [WW-1:0] w);
      bit   ev_tmo, ev_ov, ev_val, s;
      int   per;
      res_t r;
      ev_tmo = 1'b0;
      ev_ov  = 1'b0;
      ev_val = 1'b0;
      wave_in = w;
      if (en_m && cyc > en_since && cyc == tmo_ref + FULL) begin
         ev_tmo    = 1'b1;
         have_prev = 1'b0;
         tmo_ref   = cyc;
      end
      if (edge_pend && en_m && cyc > en_since) begin
         if (have_prev) begin
            per = cyc - last_cap;
            if (due_cyc > cyc) begin
               ev_ov = 1'b1;
            end else begin
               r.cyc  = cyc + LAT;
               r.per  = per;
               r.hi   = hi_at_edge;
               r.duty = int'((longint'(hi_at_edge) * FULL) / per);
               exp_q.push_back(r);
               due_cyc = cyc + LAT;
            end
         end
         have_prev = 1'b1;
         last_cap  = cyc;
         tmo_ref   = cyc;
      end
      edge_pend = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         r = exp_q.pop_front();
         ev_val   = 1'b1;
         exp_per  = r.per;
         exp_hi   = r.hi;
         exp_duty = r.duty;
      end
      @(negedge clk);
      chk("meas_valid", meas_valid, ev_val);
      chk("overrun", overrun, ev_ov);
      chk("timeout", timeout, ev_tmo);
      chk("period", period, exp_per);
      chk("high_time", high_time, exp_hi);
      chk("duty_cyc", duty_cyc, exp_duty);
      if (timeout === 1'b1) n_tmo++;
      if (overrun === 1'b1) n_ov++;
      s = (w >= threshold);
      if (s && !prev_s) begin
         edge_pend  = 1'b1;
         hi_at_edge = hi_acc;
         hi_acc     = 1;
      end else if (s) begin
         hi_acc++;
      end
      prev_s = s;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input bit hi, input int n);
      for (int i = 0; i < n; i++) step(lvl_val(hi));
   endtask

   task automatic periods(input int p, input int h, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, h);
         drive(1'b0, p - h);
      end
   endtask

   task automatic set_en(input bit b);
      enable = b;
      if (b && !en_m) begin
         en_since  = cyc;
         tmo_ref   = cyc + 1;
         have_prev = 1'b0;
      end
      if (!b) begin
         while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
         due_cyc   = 0;
         have_prev = 1'b0;
      end
      en_m = b;
   endtask

   // Asynchronous reset asserted mid-cycle, held n cycles, released just after a clock edge.
   task automatic do_reset(input int n);
      #2;
      rst     = 1'b0;
      wave_in = '0;
      exp_q.delete();
      exp_per   = 0;
      exp_hi    = 0;
      exp_duty  = 0;
      due_cyc   = 0;
      have_prev = 1'b0;
      prev_s    = 1'b0;
      edge_pend = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_period", period, 0);
         chk("rst_high_time", high_time, 0);
         chk("rst_duty_cyc", duty_cyc, 0);
         chk("rst_meas_valid", meas_valid, 0);
         chk("rst_overrun", overrun, 0);
         chk("rst_timeout", timeout, 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      rst      = 1'b1;
      en_since = cyc;
      tmo_ref  = cyc + 1;
   endtask

   initial begin
      rst       = 1'b0;
      enable    = 1'b1;
      en_m      = 1'b1;
      wave_in   = '0;
      threshold = 16'h8000;
      do_reset(3);
      drive(1'b0, 4);

      // 70/30 square wave
      periods(100, 70, 5);
      chk("sq100_period", period, 100);
      chk("sq100_high", high_time, 70);
      chk("sq100_duty", duty_cyc, 45874);

      // 20/20 wave, divider always idle at each edge
      mark_ov = n_ov;
      periods(40, 20, 4);
      chk("sq40_period", period, 40);
      chk("sq40_high", high_time, 20);
      chk("sq40_duty", duty_cyc, 32767);
      chk("sq40_no_overrun", n_ov - mark_ov, 0);

      // period shorter than the divide latency: every other capture is dropped
      mark_ov = n_ov;
      periods(10, 5, 8);
      chk("sq10_period", period, 10);
      chk("sq10_high", high_time, 5);
      chk("sq10_duty", duty_cyc, 32767);
      chk("sq10_overrun_seen", (n_ov - mark_ov) >= 3, 1);

      // random periods, thresholds and sample values
      rnd_vals = 1'b1;
      for (int i = 0; i < 30; i++) begin
         int p, h;
         threshold = WW'($urandom_range(65535, 1));
         p = int'($urandom_range(120, 2));
         h = int'($urandom_range(p - 1, 1));
         periods(p, h, 1);
      end
      rnd_vals  = 1'b0;
      threshold = 16'h8000;
      drive(1'b0, 3);

      // enable dropped while a division is in flight, then re-armed
      periods(100, 70, 2);
      drive(1'b1, 5);
      set_en(1'b0);
      drive(1'b1, 20);
      set_en(1'b1);
      drive(1'b1, 45);
      drive(1'b0, 30);
      periods(100, 70, 3);

      // reset five cycles after a capture, then resume
      periods(100, 70, 2);
      drive(1'b1, 6);
      do_reset(4);
      drive(1'b0, 10);
      periods(100, 70, 3);
      chk("post_rst_period", period, 100);
      chk("post_rst_high", high_time, 70);

      // level stuck high after an edge
      periods(40, 20, 3);
      mark_tmo = n_tmo;
      drive(1'b1, FULL + 40);
      chk("tmo_count", n_tmo - mark_tmo, 1);
      chk("tmo_hold_period", period, 40);
      chk("tmo_hold_high", high_time, 20);
      chk("tmo_hold_duty", duty_cyc, 32767);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
